// File: rtl/kmac_msg_fifo.sv
// ---------------------------------------------------------------------------
// kmac_msg_fifo
//
// Message buffer between the 32-bit KMAC register write path and the 64-bit
// SHA3 absorb datapath. Pairs of register writes are packed into one message
// word (low half = earlier write) and queued in a small FIFO. A write flagged
// wlast while no half is pending is pushed alone as a half word (mask 0x0F).
//
// Optional feature macro: KMAC_MSG_FIFO_ERR_EN
//   defined   : err is a sticky flag for write overruns (wvalid && !wready)
//               and read underruns (rready && !rvalid), cleared by err_clr.
//   undefined : err is tied low and err_clr is ignored.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous flush of FIFO and packer (err untouched)
//   wvalid/wready   register write handshake, wdata, wlast (end of message)
//   rvalid/rready   head-of-FIFO handshake, rdata, rmask, rlast
//   fifo_depth      occupied entries, zero-extended to DepthW+1 bits
//   fifo_empty      no entries
//   fifo_full       Depth entries
//   err, err_clr    sticky protocol error and its clear
// ---------------------------------------------------------------------------
module kmac_msg_fifo #(
  parameter int RegWidth = 32,
  parameter int MsgWidth = 64,
  parameter int Depth    = 10,
  parameter int DepthW   = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [RegWidth-1:0]   wdata,
  input  logic                  wlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [MsgWidth-1:0]   rdata,
  output logic [MsgWidth/8-1:0] rmask,
  output logic                  rlast,
  output logic [DepthW:0]       fifo_depth,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int MaskW = MsgWidth / 8;
  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [PtrW-1:0]   LastPtr   = PtrW'(Depth - 1);
  localparam logic [DepthW-1:0] FullCount = DepthW'(Depth);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HALF = 1'b1
  } pack_state_e;

  pack_state_e           state_q, state_d;
  logic [RegWidth-1:0]   low_q, low_d;
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [DepthW-1:0]     count_q, count_d;

  // Entry storage. Only the word, a full/half flag and the last flag are kept;
  // the byte mask is rebuilt from the flag on the way out.
  logic [MsgWidth-1:0]   mem_data_q [Depth];
  logic                  mem_full_q [Depth];
  logic                  mem_last_q [Depth];

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [MsgWidth-1:0]   push_data;
  logic                  push_full;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    // Explicit wrap so non-power-of-two depths work.
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Handshake status comes from registered state only.
  assign fifo_full  = (count_q == FullCount);
  assign fifo_empty = (count_q == '0);
  assign wready     = !fifo_full;
  assign rvalid     = !fifo_empty;
  assign fifo_depth = {1'b0, count_q};

  // clear blocks every write and pop in its cycle.
  assign accept = wvalid && wready && !clear;
  assign push   = accept && ((state_q == ST_HALF) || wlast);
  assign pop    = rvalid && rready && !clear;

  assign push_full = (state_q == ST_HALF);
  assign push_data = push_full ? {wdata, low_q}
                               : {{(MsgWidth - RegWidth){1'b0}}, wdata};

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      state_d = ST_IDLE;
      low_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (accept) begin
        if (state_q == ST_HALF) begin
          state_d = ST_IDLE;
        end else if (!wlast) begin
          state_d = ST_HALF;
          low_d   = wdata;
        end
      end
      if (push) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      // Simultaneous push and pop leaves the count unchanged.
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      low_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wptr_q] <= push_data;
      mem_full_q[wptr_q] <= push_full;
      mem_last_q[wptr_q] <= wlast;
    end
  end

  // Head outputs are gated by rvalid so an empty FIFO (and reset) shows zeros
  // instead of stale or uninitialised storage.
  always_comb begin
    rdata = '0;
    rmask = '0;
    rlast = 1'b0;
    if (rvalid) begin
      rdata = mem_data_q[rptr_q];
      rmask = mem_full_q[rptr_q] ? {MaskW{1'b1}}
                                 : {{(MaskW / 2){1'b0}}, {(MaskW / 2){1'b1}}};
      rlast = mem_last_q[rptr_q];
    end
  end

`ifdef KMAC_MSG_FIFO_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = (wvalid && !wready) || (rready && !rvalid);

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_kmac_msg_fifo.sv
// ---------------------------------------------------------------------------
// tb_kmac_msg_fifo
//
// Self-checking bench for kmac_msg_fifo. A queue-based reference model holds
// the expected FIFO contents and packer half; every cycle the DUT outputs are
// compared against it, and directed scenarios add constant expectations.
// Define KMAC_MSG_FIFO_ERR_EN for both bench and RTL to exercise err.
// ---------------------------------------------------------------------------
module tb_kmac_msg_fifo;

  localparam int DEPTH = 10;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        wlast;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [7:0]  rmask;
  logic        rlast;
  logic [4:0]  fifo_depth;
  logic        fifo_empty;
  logic        fifo_full;
  logic        err;
  logic        err_clr;

  kmac_msg_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wlast      (wlast),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rmask      (rmask),
    .rlast      (rlast),
    .fifo_depth (fifo_depth),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .err        (err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  mask;
    logic        last;
  } ent_t;

  // Reference model
  ent_t        mq[$];
  logic        m_half;
  logic [31:0] m_low;
  logic        m_err;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_half = 1'b0;
    m_low  = '0;
    m_err  = 1'b0;
  endtask

  // Compare all outputs with the model's view of the current state.
  task automatic check_state();
    int n;
    n = mq.size();
    check("wready", wready, n < DEPTH);
    check("rvalid", rvalid, n > 0);
    check("empty", fifo_empty, n == 0);
    check("full", fifo_full, n == DEPTH);
    check("depth", fifo_depth, n);
    check("err", err, m_err);
    if (n > 0) begin
      check("rdata", rdata, mq[0].data);
      check("rmask", rmask, mq[0].mask);
      check("rlast", rlast, mq[0].last);
    end
  endtask

  // Called at a negedge: check, drive, advance model, move to next negedge.
  task automatic cycle(input logic wv, input logic [31:0] wd, input logic wl,
                       input logic rr, input logic clr, input logic ec);
    int   n;
    logic set;
    ent_t e;
    check_state();
    wvalid  = wv;
    wdata   = wd;
    wlast   = wl;
    rready  = rr;
    clear   = clr;
    err_clr = ec;
    n = mq.size();
`ifdef KMAC_MSG_FIFO_ERR_EN
    set = (wv && n == DEPTH) || (rr && n == 0);
    if (set) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
`else
    set = 1'b0;
    m_err = set;
`endif
    if (clr) begin
      mq.delete();
      m_half = 1'b0;
    end else begin
      if (rr && n > 0) e = mq.pop_front();
      if (wv && n < DEPTH) begin
        if (m_half) begin
          e.data = {wd, m_low};
          e.mask = 8'hFF;
          e.last = wl;
          mq.push_back(e);
          m_half = 1'b0;
        end else if (wl) begin
          e.data = {32'h0, wd};
          e.mask = 8'h0F;
          e.last = 1'b1;
          mq.push_back(e);
        end else begin
          m_half = 1'b1;
          m_low  = wd;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++)
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    clear   = 1'b0;
    wvalid  = 1'b0;
    wdata   = '0;
    wlast   = 1'b0;
    rready  = 1'b0;
    err_clr = 1'b0;
    model_reset();

    // Reset state
    #2;
    check("rst_wready", wready, 1'b1);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_depth", fifo_depth, 5'd0);
    check("rst_rdata", rdata, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");

    // Packed pair
    cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pair_depth0", fifo_depth, 5'd0);
    cycle(1'b1, 32'h5A5A_0002, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pair_depth1", fifo_depth, 5'd1);
    check("pair_rdata", rdata, 64'h5A5A_0002_A5A5_0001);
    check("pair_rmask", rmask, 8'hFF);
    check("pair_rlast", rlast, 1'b1);
    $display("pair: rdata=%h rmask=%h", rdata, rmask);
    drain();

    // Single half word
    cycle(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
    check("half_rdata", rdata, 64'h0000_0000_1234_5678);
    check("half_rmask", rmask, 8'h0F);
    check("half_rlast", rlast, 1'b1);
    $display("half: rdata=%h rmask=%h", rdata, rmask);
    drain();

    // Fill to full
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fill_full", fifo_full, 1'b1);
    check("fill_depth", fifo_depth, 5'd10);
    check("fill_wready", wready, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef KMAC_MSG_FIFO_ERR_EN
    check("ovr_err", err, 1'b1);
`endif
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pop_full", fifo_full, 1'b0);
    check("pop_depth", fifo_depth, 5'd9);
    $display("full: one pop -> depth=%0d", fifo_depth);

    // Refill, then drain back-to-back across pointer wrap
    cycle(1'b1, 32'hE000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hE000_0002, 1'b1, 1'b0, 1'b0, 1'b1);
    check("refill_full", fifo_full, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", fifo_empty, 1'b1);
    check("drain_rvalid", rvalid, 1'b0);
    $display("drain: empty=%0d", fifo_empty);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Clear discards a pending half
    cycle(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_depth", fifo_depth, 5'd0);
    cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 1'b0);
    check("clr_fresh", rdata, 64'h2222_2222_1111_1111);
    $display("clear: fresh rdata=%h", rdata);
    drain();

    // Asynchronous reset with six entries
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 32'hF000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ar_depth6", fifo_depth, 5'd6);
    #2 rst = 1'b1;
    #1;
    check("ar_rvalid", rvalid, 1'b0);
    check("ar_depth", fifo_depth, 5'd0);
    check("ar_empty", fifo_empty, 1'b1);
    check("ar_err", err, 1'b0);
    $display("async reset: rvalid=%0d depth=%0d", rvalid, fifo_depth);
    wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
            $urandom_range(0, 9) == 0);
    end
    check_state();
    $display("random: 600 cycles done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kmac_msg_fifo.md
Name: kmac_msg_fifo

Overview:
- Message buffer between the 32-bit KMAC register write interface and the 64-bit SHA3 absorb datapath.
- Packs pairs of 32-bit register writes into 64-bit message words and stores them in a FIFO.
- Exports the entry count to the status register's fifo_depth field, which is 5 bits wide (MsgFifoDepthW+1).
- Default depth equals the KMAC package MsgFifoDepth, which is 10.

Parameters:
- RegWidth, 32, write-side word width (RegIntfWidth).
- MsgWidth, 64, read-side word width; must equal 2*RegWidth.
- Depth, 10, number of 64-bit FIFO entries (MsgFifoDepth).
- DepthW, 4, $clog2(Depth+1) (MsgFifoDepthW).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- clear  input  1  synchronous flush of FIFO and packer
- wvalid  input  1  register write valid
- wready  output  1  write accepted when high with wvalid
- wdata  input  RegWidth  write data
- wlast  input  1  last word of message; flushes a pending low half
- rvalid  output  1  FIFO head valid
- rready  input  1  consumer accepts head
- rdata  output  MsgWidth  head data; low half is the earlier write
- rmask  output  MsgWidth/8  byte mask of head: 8'hFF full word, 8'h0F half word
- rlast  output  1  head word ends a message
- fifo_depth  output  DepthW+1  occupied entries, zero-extended
- fifo_empty  output  1  fifo_depth==0
- fifo_full  output  1  fifo_depth==Depth
- err  output  1  sticky protocol error (see Optional Feature)
- err_clr  input  1  clears err

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values: all outputs are 0, except fifo_empty=1 and wready=1.
  - Internal state: packer=IDLE, pointers=0, count=0.
- Packer FSM has two states: IDLE (no pending half) and HALF (low half held in a 32-bit register).
  - IDLE, write accepted, wlast=0: store wdata as low half; go to HALF. No push.
  - IDLE, write accepted, wlast=1: push {32'h0, wdata}, mask 8'h0F, rlast=1; stay IDLE.
  - HALF, write accepted: push {wdata, low}, mask 8'hFF, rlast=wlast; go to IDLE.
- wready is a function of registered state only: wready = !fifo_full. A write in IDLE without wlast is held back while full; this keeps the logic simple.
- Read handshake: a pop occurs when rvalid && rready.
  - rvalid = !fifo_empty.
  - rdata, rmask and rlast are driven combinationally from the head entry.
- Latency: a pushed entry is visible on rvalid in the cycle after the accepting write edge. There is no write-to-read bypass.
- Count: increments on push only, decrements on pop only, and is unchanged when both occur in the same cycle.
- Simultaneous push and pop while full: not possible, because wready=0 when full. A pop while full lowers fifo_full in the next cycle.
- Pop while empty: not possible (rvalid=0); rready is ignored.
- Pointers: read and write pointers wrap from Depth-1 to 0. Depth need not be a power of 2.
- clear has priority over every other event in its cycle:
  - count, pointers and packer return to reset values;
  - any pending half is discarded;
  - wready stays as computed before the clear edge, but no write is accepted in a clear cycle;
  - err is not affected.
- Reset mid-operation: asynchronous; contents are discarded immediately and rvalid drops without waiting for a clock edge.
- fifo_depth width: DepthW+1 = 5 bits, matching the status field, so fifo_depth = {1'b0, count}.

Optional Feature:
- Macro: KMAC_MSG_FIFO_ERR_EN.
- Defined: err sets on the next edge when either condition occurs:
  - wvalid && !wready, i.e. a write dropped by a software overrun;
  - rready && !rvalid, i.e. an underrun request.
  - err stays high until err_clr or rst. If err_clr and a new error occur in the same cycle, set wins.
- Undefined: err is tied to 0, err_clr is ignored, and no error logic is synthesized.

Test Plan:
- Two writes 32'hA5A5_0001 then 32'h5A5A_0002 (wlast=1 on the second) -> one entry: rdata=64'h5A5A_0002_A5A5_0001, rmask=8'hFF, rlast=1; fifo_depth goes 0->1 one cycle after the second write.
- Single write 32'h1234_5678 with wlast=1 -> rdata=64'h0000_0000_1234_5678, rmask=8'h0F, rlast=1.
- 20 writes with rready=0 -> fifo_full=1 and fifo_depth=5'd10 after 20 accepted writes; 21st write sees wready=0; with ERR_EN, err=1 when wvalid held; one pop -> fifo_full=0, fifo_depth=9.
- Full FIFO drained with rready=1 continuously -> 10 pops in consecutive cycles, data in write order across pointer wrap, then fifo_empty=1, rvalid=0.
- One write (packer HALF) then clear -> fifo_depth=0; next write pair forms a fresh entry with no stale low half.
- rst asserted asynchronously mid-burst with 6 entries -> rvalid=0, fifo_depth=0 and fifo_empty=1 before the next clk edge; err=0.
